// File: rtl/fft_frame_ctrl.sv
// Ping-pong frame scheduler: packs FIR samples into 16-sample frames and hands them to the FFT one at a time.
// Optional WAIT watchdog enabled by defining FRAME_CTRL_TIMEOUT_EN.
module fft_frame_ctrl #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fir_valid,
    input  logic [WIDTH-1:0]    fir_d,
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic [16*WIDTH-1:0] frame_data,
    input  logic                ana_done,
    input  logic [3:0]          ana_freq,
    output logic                freq_valid,
    output logic [3:0]          freq,
    output logic                busy,
    output logic                overrun,
    output logic                timeout
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t           state_reg, state_next;
    logic             wr_bank_reg, rd_bank_reg;
    logic [3:0]       wr_cnt_reg;
    logic [1:0]       full_reg, full_next;
    logic             freq_valid_reg, overrun_reg, timeout_reg;
    logic [3:0]       freq_reg;
    logic [WIDTH-1:0] mem [0:31];

    logic done_hit, expire, release_bank, wr_ok, wr_en, fill_done;

    assign done_hit = (state_reg == WAIT) && ana_done;

`ifdef FRAME_CTRL_TIMEOUT_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wd_cnt_reg;

    // Held at zero outside WAIT so every WAIT visit starts counting from entry.
    always_ff @(posedge clk) begin
        if (rst || state_reg != WAIT) begin
            wd_cnt_reg <= '0;
        end else begin
            wd_cnt_reg <= wd_cnt_reg + 8'd1;
        end
    end

    assign expire = (state_reg == WAIT) && !ana_done && (wd_cnt_reg == WD_LAST);
`else
    // Watchdog compiled out; TIMEOUT only keeps the parameter list identical across builds.
    assign expire = (TIMEOUT < 0);
`endif

    assign release_bank = done_hit || expire;
    assign wr_ok        = !full_reg[wr_bank_reg] || (release_bank && (rd_bank_reg == wr_bank_reg));
    assign wr_en        = fir_valid && wr_ok;
    assign fill_done    = wr_en && (wr_cnt_reg == 4'd15);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank_reg, wr_cnt_reg}] <= fir_d;
        end
    end

    always_comb begin
        full_next = full_reg;
        if (release_bank) begin
            full_next[rd_bank_reg] = 1'b0;
        end
        if (fill_done) begin
            full_next[wr_bank_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_reg    <= 1'b0;
            rd_bank_reg    <= 1'b0;
            wr_cnt_reg     <= '0;
            full_reg       <= '0;
            overrun_reg    <= 1'b0;
            freq_valid_reg <= 1'b0;
            freq_reg       <= '0;
            timeout_reg    <= 1'b0;
        end else begin
            full_reg       <= full_next;
            freq_valid_reg <= done_hit;
            timeout_reg    <= expire;
            if (wr_en) begin
                wr_cnt_reg <= wr_cnt_reg + 4'd1;
            end
            if (fill_done) begin
                wr_bank_reg <= ~wr_bank_reg;
            end
            if (fir_valid && !wr_ok) begin
                overrun_reg <= 1'b1;
            end
            if (release_bank) begin
                rd_bank_reg <= ~rd_bank_reg;
            end
            if (done_hit) begin
                freq_reg <= ana_freq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (full_reg[rd_bank_reg]) state_next = ISSUE;
            ISSUE:   if (frame_ready)           state_next = WAIT;
            WAIT:    if (release_bank)          state_next = IDLE;
            default:                            state_next = IDLE;
        endcase
    end

    always_comb begin
        frame_valid = (state_reg == ISSUE);
        busy        = (state_reg != IDLE);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_frame
            assign frame_data[WIDTH*gi +: WIDTH] = frame_valid ? mem[{rd_bank_reg, 4'(gi)}] : '0;
        end
    endgenerate

    assign freq_valid = freq_valid_reg;
    assign freq       = freq_reg;
    assign overrun    = overrun_reg;
    assign timeout    = timeout_reg;
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl: directed scenarios plus random traffic against a frame-queue model.
// Honours FRAME_CTRL_TIMEOUT_EN when the design is built with the watchdog.
module tb_fft_frame_ctrl;
    localparam int W  = 16;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst, fir_valid, frame_ready, ana_done;
    logic [W-1:0]  fir_d;
    logic [3:0]    ana_freq;
    logic          frame_valid, freq_valid, busy, overrun, timeout;
    logic [16*W-1:0] frame_data;
    logic [3:0]    freq;

    fft_frame_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .fir_valid(fir_valid), .fir_d(fir_d),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_data(frame_data),
        .ana_done(ana_done), .ana_freq(ana_freq), .freq_valid(freq_valid), .freq(freq),
        .busy(busy), .overrun(overrun), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: completed frames waiting or in flight, oldest first, with the cycle each completed.
    logic [16*W-1:0] m_pend[$];
    int              m_pend_cyc[$];
    logic [16*W-1:0] m_part;
    int              m_part_cnt;
    bit              m_inflight;
    int              m_wait_start;
    int              m_last_retire;
    logic [3:0]      m_freq;
    bit              m_freq_valid, m_overrun, m_timeout;

    task automatic check(input string tag, input logic [16*W-1:0] obs, input logic [16*W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend.delete();
        m_pend_cyc.delete();
        m_part        = '0;
        m_part_cnt    = 0;
        m_inflight    = 0;
        m_wait_start  = 0;
        m_last_retire = -100;
        m_freq        = '0;
        m_freq_valid  = 0;
        m_overrun     = 0;
        m_timeout     = 0;
    endtask

    task automatic step(input bit r, input bit fv, input logic [W-1:0] d,
                        input bit fr, input bit ad, input logic [3:0] af);
        bit exp_fv, retire, expire;
        int ready_at;
        logic [16*W-1:0] exp_fd;
        rst = r; fir_valid = fv; fir_d = d; frame_ready = fr; ana_done = ad; ana_freq = af;
        @(negedge clk);
        exp_fv = 0;
        if (m_pend.size() > 0 && !m_inflight) begin
            ready_at = m_pend_cyc[0] + 2;
            if (m_last_retire + 2 > ready_at) ready_at = m_last_retire + 2;
            exp_fv = (cyc >= ready_at);
        end
        exp_fd = exp_fv ? m_pend[0] : '0;
        check("frame_valid", 256'(frame_valid), 256'(exp_fv));
        check("frame_data",  frame_data, exp_fd);
        check("busy",        256'(busy), 256'(exp_fv || m_inflight));
        check("freq_valid",  256'(freq_valid), 256'(m_freq_valid));
        check("freq",        256'(freq), 256'(m_freq));
        check("overrun",     256'(overrun), 256'(m_overrun));
        check("timeout",     256'(timeout), 256'(m_timeout));

        retire = m_inflight && ad;
        expire = 0;
`ifdef FRAME_CTRL_TIMEOUT_EN
        expire = m_inflight && !ad && (cyc - m_wait_start == TO - 1);
`endif
        m_freq_valid = retire;
        m_timeout    = expire;
        if (fv) begin
            if (m_pend.size() < 2 || retire || expire) begin
                m_part[W*m_part_cnt +: W] = d;
                m_part_cnt++;
                if (m_part_cnt == 16) begin
                    m_pend.push_back(m_part);
                    m_pend_cyc.push_back(cyc);
                    m_part     = '0;
                    m_part_cnt = 0;
                end
            end else begin
                m_overrun = 1;
            end
        end
        if (retire) m_freq = af;
        if (retire || expire) begin
            void'(m_pend.pop_front());
            void'(m_pend_cyc.pop_front());
            m_inflight    = 0;
            m_last_retire = cyc;
        end
        if (exp_fv && fr) begin
            m_inflight   = 1;
            m_wait_start = cyc + 1;
        end
        if (r) model_reset();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n, input bit fr);
        for (int i = 0; i < n; i++) step(0, 0, '0, fr, 0, 4'd0);
    endtask

    initial begin
        rst = 1; fir_valid = 0; fir_d = '0; frame_ready = 0; ana_done = 0; ana_freq = '0;
        model_reset();
        @(posedge clk);
        #1;
        step(1, 0, '0, 0, 0, 4'd0);

        // Sequential samples 1..16, FFT always ready, then retire with frequency 5.
        for (int i = 1; i <= 16; i++) step(0, 1, W'(i), 1, 0, 4'd0);
        idle(4, 1);
        step(0, 0, '0, 1, 1, 4'd5);
        idle(3, 1);

        // Fill both banks while the FFT stalls; the third frame's samples are dropped.
        for (int i = 0; i < 48; i++) step(0, 1, W'($urandom), 0, 0, 4'd0);
        idle(4, 1);
        step(0, 0, '0, 1, 1, 4'd3);
        idle(4, 1);
        step(0, 0, '0, 1, 1, 4'd12);
        idle(3, 1);

        // Reset while in WAIT with the second bank half full; stale done must be ignored.
        for (int i = 0; i < 16; i++) step(0, 1, W'($urandom), 1, 0, 4'd0);
        idle(3, 1);
        for (int i = 0; i < 8; i++) step(0, 1, W'($urandom), 1, 0, 4'd0);
        step(1, 0, '0, 1, 0, 4'd0);
        step(0, 0, '0, 1, 1, 4'd9);
        for (int i = 0; i < 16; i++) step(0, 1, W'(16'h100 + i), 1, 0, 4'd0);
        idle(4, 1);
        step(0, 0, '0, 1, 1, 4'd7);
        idle(2, 1);

        // Frame accepted but never analysed: watchdog expiry or a persistent WAIT.
        step(1, 0, '0, 0, 0, 4'd0);
        for (int i = 0; i < 16; i++) step(0, 1, W'($urandom), 1, 0, 4'd0);
        idle(80, 1);
        for (int i = 0; i < 20; i++) step(0, 1, W'($urandom), 1, 0, 4'd0);
        idle(5, 1);

        // Random traffic with occasional resets.
        step(1, 0, '0, 0, 0, 4'd0);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 700) == 0, ($urandom % 4) != 0, W'($urandom),
                 ($urandom % 3) != 0, ($urandom % 8) == 0, 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
